// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through data cache with per-set round-robin replacement.
// One-word lines: loads refill on miss, stores write through and update only on a hit.
module set_assoc_cache #(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              mmu_clk,
    input  logic              i_rst,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [4:0]        rd_req_reg,
    input  logic [2:0]        rd_req_func3,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [4:0]        rd_valid_reg,
    output logic [2:0]        rd_valid_func3,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [2:0]        wr_req_func3,
    output logic              wr_done,

    input  logic              flush,
    output logic              ready,

    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,

    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_strb,
    input  logic              mem_wr_done
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WTHRU, RESP} state_t;

    state_t state_q, state_d;
    logic   ready_q;

    logic [ADDR_W-1:0] addr_q;
    logic              is_wr_q;
    logic [4:0]        reg_q;
    logic [2:0]        func3_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;
    logic [31:0]       word_q;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             has_inv;
    logic [WAY_W-1:0] victim;
    logic             accept, take_flush, take_wr, take_rd;
    logic             refill_fire;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    assign idx = addr_q[2 +: IDX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    assign accept     = (state_q == IDLE) && ready_q;
    assign take_flush = accept && flush;
    assign take_wr    = accept && !flush && wr_req;
    assign take_rd    = accept && !flush && !wr_req && rd_req;

    assign refill_fire = (state_q == REFILL) && mem_rd_valid;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Walk downwards so the lowest-index invalid way wins; fall back to round-robin.
    always_comb begin
        has_inv = 1'b0;
        victim  = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                victim  = WAY_W'(w);
            end
        end
    end

    always_comb begin
        st_strb = 4'b1111;
        st_data = wr_data;
        case (wr_req_func3)
            3'b000: begin
                st_strb = 4'b0001 << wr_addr[1:0];
                st_data = {4{wr_data[7:0]}};
            end
            3'b001: begin
                st_strb = wr_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_wr || take_rd) state_d = LOOKUP;
            LOOKUP:  state_d = is_wr_q ? WTHRU : (hit ? RESP : REFILL);
            REFILL:  if (mem_rd_valid) state_d = RESP;
            WTHRU:   if (mem_wr_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mmu_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            reg_q   <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (take_wr) begin
                addr_q  <= wr_addr;
                is_wr_q <= 1'b1;
                func3_q <= wr_req_func3;
                wdata_q <= st_data;
                strb_q  <= st_strb;
            end else if (take_rd) begin
                addr_q  <= rd_addr;
                is_wr_q <= 1'b0;
                reg_q   <= rd_req_reg;
                func3_q <= rd_req_func3;
            end
            if ((state_q == LOOKUP) && !is_wr_q && hit) begin
                word_q <= data_q[hit_way][idx];
            end else if (refill_fire) begin
                word_q <= mem_rd_data;
            end
        end
    end

    always_ff @(posedge mmu_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (take_flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (refill_fire) begin
            valid_q[idx][victim] <= 1'b1;
            if (!has_inv) begin
                rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset: contents are only trusted behind a valid bit.
    always_ff @(posedge mmu_clk) begin
        if (refill_fire) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= mem_rd_data;
        end else if ((state_q == LOOKUP) && is_wr_q && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) data_q[hit_way][idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        ld_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (func3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = word_q;
        endcase
    end

    assign ready          = ready_q;
    assign rd_valid       = (state_q == RESP) && !is_wr_q;
    assign wr_done        = (state_q == RESP) && is_wr_q;
    assign rd_data        = rd_valid ? ld_data : '0;
    assign rd_valid_reg   = rd_valid ? reg_q : '0;
    assign rd_valid_func3 = rd_valid ? func3_q : '0;

    assign mem_rd_req  = (state_q == REFILL);
    assign mem_rd_addr = mem_rd_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wr_req  = (state_q == WTHRU);
    assign mem_wr_addr = mem_wr_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wr_data = mem_wr_req ? wdata_q : '0;
    assign mem_wr_strb = mem_wr_req ? strb_q : '0;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized bench for set_assoc_cache: directed scenarios plus random loads/stores/flushes
// checked against an array-based cache and memory model.
module tb_set_assoc_cache;

    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 64;
    localparam int unsigned ADDR_W = 32;

    logic              mmu_clk, i_rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [4:0]        rd_req_reg;
    logic [2:0]        rd_req_func3;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [4:0]        rd_valid_reg;
    logic [2:0]        rd_valid_func3;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [2:0]        wr_req_func3;
    logic              wr_done;
    logic              flush, ready;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_valid;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_strb;
    logic              mem_wr_done;

    set_assoc_cache #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .mmu_clk(mmu_clk), .i_rst(i_rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_reg(rd_req_reg),
        .rd_req_func3(rd_req_func3), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_valid_reg(rd_valid_reg), .rd_valid_func3(rd_valid_func3),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_req_func3(wr_req_func3), .wr_done(wr_done),
        .flush(flush), .ready(ready),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .mem_wr_done(mem_wr_done)
    );

    initial mmu_clk = 1'b0;
    always #5 mmu_clk = ~mmu_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each way remembers the full line (word) address it holds.
    bit          m_valid [SETS][WAYS];
    bit   [31:0] m_line  [SETS][WAYS];
    bit   [31:0] m_data  [SETS][WAYS];
    int          m_rr    [SETS];
    bit   [31:0] mem_m   [bit [31:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mmu_clk);
        #1;
    endtask

    function automatic bit [31:0] mem_word(input bit [31:0] wa);
        if (mem_m.exists(wa)) return mem_m[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic int set_of(input bit [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic int model_find(input bit [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == (a >> 2)) return w;
        return -1;
    endfunction

    function automatic bit [31:0] extract(input bit [31:0] word, input bit [31:0] a,
                                          input bit [2:0] f3);
        bit [31:0] b, h;
        b = (word >> (8 * a[1:0])) & 32'hFF;
        h = (word >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d,
                                        input bit [3:0] strb);
        bit [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
        check("ready_wait", ready, 1);
    endtask

    task automatic do_load(input bit [31:0] a, input bit [2:0] f3,
                           output bit [31:0] data, output int refills, output int lat);
        int s, way, rv_cyc, wcnt, victim;
        bit seen;
        bit [4:0] rtag, got_reg;
        bit [2:0] got_f3;
        bit [31:0] wa, exp_word;
        s = set_of(a);
        wa = {a[31:2], 2'b00};
        way = model_find(a);
        exp_word = (way < 0) ? mem_word(wa) : m_data[s][way];
        rtag = 5'($urandom_range(0, 31));
        data = 0; refills = 0; lat = -1; rv_cyc = -1; seen = 0; wcnt = 0;
        got_reg = 0; got_f3 = 0;
        wait_ready();
        rd_req = 1; rd_addr = a; rd_req_func3 = f3; rd_req_reg = rtag;
        tick();
        rd_req = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            mem_rd_valid = 0;
            if (rd_valid) begin
                lat = cyc; data = rd_data; got_reg = rd_valid_reg; got_f3 = rd_valid_func3;
                break;
            end
            if (mem_rd_req) begin
                if (!seen) begin
                    seen = 1;
                    check("ld_refill_addr", mem_rd_addr, wa);
                    wcnt = $urandom_range(0, 3);
                end
                if (wcnt == 0) begin
                    mem_rd_valid = 1; mem_rd_data = mem_word(wa);
                    rv_cyc = cyc; refills++; seen = 0;
                end else wcnt--;
            end
            tick();
        end
        mem_rd_valid = 0;
        if (lat < 0) check("ld_timeout", 0, 1);
        check("ld_refills", refills, (way < 0) ? 1 : 0);
        check("ld_data", data, extract(exp_word, a, f3));
        check("ld_reg", got_reg, rtag);
        check("ld_func3", got_f3, f3);
        if (way < 0) check("ld_lat_miss", lat, rv_cyc + 1);
        else         check("ld_lat_hit", lat, 2);
        if (way < 0) begin
            victim = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) victim = w;
            if (victim < 0) begin
                victim = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][victim] = 1; m_line[s][victim] = a >> 2; m_data[s][victim] = exp_word;
        end
        tick();
        check("ld_pulse", rd_valid, 0);
    endtask

    task automatic do_store(input bit [31:0] a, input bit [31:0] d, input bit [2:0] f3,
                            output bit [3:0] obs_strb, output bit [31:0] obs_data);
        int way, wd_cyc, lat, wcnt;
        bit seen, rd_seen;
        bit [3:0] e_strb;
        bit [31:0] e_data, wa;
        wa = {a[31:2], 2'b00};
        case (f3)
            3'd0:    begin e_strb = 4'b0001 << a[1:0]; e_data = {4{d[7:0]}}; end
            3'd1:    begin e_strb = a[1] ? 4'b1100 : 4'b0011; e_data = {2{d[15:0]}}; end
            default: begin e_strb = 4'b1111; e_data = d; end
        endcase
        way = model_find(a);
        obs_strb = 0; obs_data = 0; lat = -1; wd_cyc = -1; seen = 0; rd_seen = 0; wcnt = 0;
        wait_ready();
        wr_req = 1; wr_addr = a; wr_data = d; wr_req_func3 = f3;
        tick();
        wr_req = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            mem_wr_done = 0;
            if (wr_done) begin lat = cyc; break; end
            if (mem_rd_req) rd_seen = 1;
            if (mem_wr_req && wd_cyc < 0) begin
                if (!seen) begin
                    seen = 1;
                    obs_strb = mem_wr_strb; obs_data = mem_wr_data;
                    check("st_addr", mem_wr_addr, wa);
                    check("st_strb", mem_wr_strb, e_strb);
                    check("st_data", mem_wr_data, e_data);
                    wcnt = $urandom_range(0, 3);
                end
                if (wcnt == 0) begin mem_wr_done = 1; wd_cyc = cyc; end
                else wcnt--;
            end
            tick();
        end
        mem_wr_done = 0;
        if (lat < 0) check("st_timeout", 0, 1);
        check("st_lat", lat, wd_cyc + 1);
        check("st_no_refill", rd_seen, 0);
        mem_m[wa] = merge(mem_word(wa), e_data, e_strb);
        if (way >= 0) m_data[set_of(a)][way] = merge(m_data[set_of(a)][way], e_data, e_strb);
        tick();
        check("st_pulse", wr_done, 0);
    endtask

    task automatic do_flush();
        wait_ready();
        flush = 1;
        tick();
        flush = 0;
        check("flush_ready", ready, 1);
        model_clear();
    endtask

    initial begin
        bit [31:0] d, a, sd;
        bit [3:0]  ostrb;
        int r, l, op;

        i_rst = 1; rd_req = 0; rd_addr = 0; rd_req_reg = 0; rd_req_func3 = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0; wr_req_func3 = 0; flush = 0;
        mem_rd_valid = 0; mem_rd_data = 0; mem_wr_done = 0;
        model_clear();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        mem_m[32'h1000] = 32'hDEAD_BEEF;
        tick(); tick();
        check("rst_ready", ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_mem_rd_req", mem_rd_req, 0);
        check("rst_mem_wr_req", mem_wr_req, 0);
        check("rst_wr_done", wr_done, 0);
        i_rst = 0;

        // Cold miss then hit, then sub-word extraction.
        do_load(32'h1000, 3'd2, d, r, l);
        check("s1_data", d, 32'hDEAD_BEEF);
        check("s1_refill", r, 1);
        do_load(32'h1000, 3'd2, d, r, l);
        check("s1_hit_refill", r, 0);
        check("s1_hit_lat", l, 2);
        do_load(32'h1003, 3'd0, d, r, l);
        check("s2_lb", d, 32'hFFFF_FFDE);
        do_load(32'h1003, 3'd4, d, r, l);
        check("s2_lbu", d, 32'h0000_00DE);
        do_load(32'h1002, 3'd5, d, r, l);
        check("s2_lhu", d, 32'h0000_DEAD);

        // WAYS+1 tags in one set: the first tag (way 0) gets evicted.
        for (int k = 1; k <= WAYS; k++) do_load(32'h1000 + k * SETS * 4, 3'd2, d, r, l);
        do_load(32'h1000, 3'd2, d, r, l);
        check("s3_first_evicted", r, 1);
        check("s3_first_data", d, 32'hDEAD_BEEF);
        do_load(32'h1000 + 2 * SETS * 4, 3'd2, d, r, l);
        check("s3_way2_kept", r, 0);
        do_load(32'h1000 + SETS * 4, 3'd2, d, r, l);
        check("s3_way1_evicted", r, 1);

        // Byte store to a cached line, then to an uncached one.
        do_store(32'h1001, 32'h55, 3'd0, ostrb, sd);
        check("s4_strb", ostrb, 4'b0010);
        check("s4_data", sd, 32'h5555_5555);
        do_load(32'h1000, 3'd2, d, r, l);
        check("s4_lw", d, 32'hDEAD_55EF);
        check("s4_lw_hit", r, 0);
        do_store(32'h3004, 32'hA7, 3'd0, ostrb, sd);
        do_load(32'h3004, 3'd2, d, r, l);
        check("s4_no_alloc", r, 1);

        // Flush wins over a simultaneous read.
        wait_ready();
        flush = 1; rd_req = 1; rd_addr = 32'h1000; rd_req_func3 = 3'd2;
        tick();
        flush = 0; rd_req = 0;
        check("s5_ready", ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("s5_no_rd_valid", rd_valid, 0);
            check("s5_no_refill", mem_rd_req, 0);
            tick();
        end
        model_clear();
        do_load(32'h1000, 3'd2, d, r, l);
        check("s5_miss_after_flush", r, 1);

        // Reset in the middle of a refill.
        wait_ready();
        rd_req = 1; rd_addr = 32'h5000; rd_req_func3 = 3'd2;
        tick();
        rd_req = 0;
        for (int i = 0; i < 10 && !mem_rd_req; i++) tick();
        check("s6_refill_req", mem_rd_req, 1);
        #2 i_rst = 1;
        #1;
        check("s6_req_drop", mem_rd_req, 0);
        check("s6_ready_low", ready, 0);
        tick();
        i_rst = 0;
        mem_rd_valid = 1; mem_rd_data = 32'h1234_5678;
        tick();
        mem_rd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("s6_no_rd_valid", rd_valid, 0);
            tick();
        end
        model_clear();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        do_load(32'h1000, 3'd2, d, r, l);
        check("s6_invalid_after_rst", r, 1);

        // Random mix over a few sets with more tags than ways.
        for (int i = 0; i < 300; i++) begin
            a = 32'h1000 + $urandom_range(0, 5) * SETS * 4 + $urandom_range(0, 2) * 4
                + $urandom_range(0, 3);
            op = $urandom_range(0, 19);
            if (op == 0) do_flush();
            else if (op < 8) do_store(a, $urandom, 3'($urandom_range(0, 7)), ostrb, sd);
            else do_load(a, 3'($urandom_range(0, 7)), d, r, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
